// File: rtl/bus_bridge.sv
// Memory-mapped bridge between the core's MEM stage and DRAM / peripheral page 0xFFFF_F000.
// Optional cycle counter TMR at 0xFFFF_F020 is built when BRIDGE_TIMER_EN is defined.
module bus_bridge #(
  parameter int unsigned DRAM_AW  = 14,
  parameter int unsigned SCAN_DIV = 2000
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic [31:0]        Bus_addr,
  input  logic               Bus_wen,
  input  logic [31:0]        Bus_wdata,
  output logic [31:0]        Bus_rdata,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_wen,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  output logic [23:0]        led,
  input  logic [23:0]        sw,
  input  logic [4:0]         button,
  output logic [7:0]         dig_en,
  output logic [7:0]         dig_seg
);
  localparam int unsigned CW = $clog2(SCAN_DIV);

  logic          w_periph, w_sel_dig, w_sel_led, w_sel_sw, w_sel_btn, w_sel_tmr;
  logic          w_unused_addr;
  logic [31:0]   r_dig;
  logic [23:0]   r_led;
  logic [23:0]   r_sw_s1, r_sw_s2;
  logic [4:0]    r_btn_s1, r_btn_s2;
  logic [CW-1:0] r_scan_cnt, w_cnt_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic          w_cnt_wrap;
  logic [31:0]   w_dig_nxt;
  logic [3:0]    w_nib;
  logic [7:0]    r_dig_en, r_dig_seg;
`ifdef BRIDGE_TIMER_EN
  logic [31:0]   r_tmr;
`endif

  assign w_unused_addr = ^Bus_addr[1:0];
  assign w_periph  = (Bus_addr[31:12] == 20'hFFFFF);
  assign w_sel_dig = w_periph & (Bus_addr[11:2] == 10'h000);
  assign w_sel_tmr = w_periph & (Bus_addr[11:2] == 10'h008);
  assign w_sel_led = w_periph & (Bus_addr[11:2] == 10'h018);
  assign w_sel_sw  = w_periph & (Bus_addr[11:2] == 10'h01C);
  assign w_sel_btn = w_periph & (Bus_addr[11:2] == 10'h01E);

  assign dram_addr  = Bus_addr[DRAM_AW+1:2];
  assign dram_wen   = Bus_wen & ~w_periph & cpu_rst;
  assign dram_wdata = Bus_wdata;
  assign led        = r_led;
  assign dig_en     = r_dig_en;
  assign dig_seg    = r_dig_seg;

  always_comb begin
    Bus_rdata = '0;
    if (!w_periph)      Bus_rdata = dram_rdata;
    else if (w_sel_dig) Bus_rdata = r_dig;
    else if (w_sel_led) Bus_rdata = {8'h00, r_led};
    else if (w_sel_sw)  Bus_rdata = {8'h00, r_sw_s2};
    else if (w_sel_btn) Bus_rdata = {27'h0, r_btn_s2};
`ifdef BRIDGE_TIMER_EN
    else if (w_sel_tmr) Bus_rdata = r_tmr;
`endif
  end

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'hC0; 4'h1: hex7 = 8'hF9; 4'h2: hex7 = 8'hA4; 4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99; 4'h5: hex7 = 8'h92; 4'h6: hex7 = 8'h82; 4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80; 4'h9: hex7 = 8'h90; 4'hA: hex7 = 8'h88; 4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6; 4'hD: hex7 = 8'hA1; 4'hE: hex7 = 8'h86; default: hex7 = 8'h8E;
    endcase
  endfunction

  // Display registers are loaded from next-state idx/DIG so dig_en always tracks idx
  // and a DIG write shows on the segments right after its edge.
  always_comb begin
    w_dig_nxt  = (Bus_wen & w_sel_dig) ? Bus_wdata : r_dig;
    w_cnt_wrap = (r_scan_cnt == CW'(SCAN_DIV - 1));
    w_cnt_nxt  = w_cnt_wrap ? '0 : r_scan_cnt + CW'(1);
    w_idx_nxt  = w_cnt_wrap ? r_idx + 3'd1 : r_idx;
    w_nib      = w_dig_nxt[{w_idx_nxt, 2'b00} +: 4];
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      r_dig      <= '0;
      r_led      <= '0;
      r_sw_s1    <= '0;
      r_sw_s2    <= '0;
      r_btn_s1   <= '0;
      r_btn_s2   <= '0;
      r_scan_cnt <= '0;
      r_idx      <= '0;
      r_dig_en   <= 8'hFE;
      r_dig_seg  <= 8'hC0;
    end else begin
      r_dig      <= w_dig_nxt;
      if (Bus_wen & w_sel_led) r_led <= Bus_wdata[23:0];
      r_sw_s1    <= sw;
      r_sw_s2    <= r_sw_s1;
      r_btn_s1   <= button;
      r_btn_s2   <= r_btn_s1;
      r_scan_cnt <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_dig_en   <= ~(8'b1 << w_idx_nxt);
      r_dig_seg  <= hex7(w_nib);
    end
  end

`ifdef BRIDGE_TIMER_EN
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst)                r_tmr <= '0;
    else if (Bus_wen & w_sel_tmr) r_tmr <= Bus_wdata;
    else                         r_tmr <= r_tmr + 32'd1;
  end
`else
  logic w_unused_tmr;
  assign w_unused_tmr = w_sel_tmr;
`endif
endmodule

// File: tb/tb_bus_bridge.sv
// Directed self-checking bench for bus_bridge (SCAN_DIV overridden to 4).
module tb_bus_bridge;
  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b0;
  logic [31:0] Bus_addr = '0;
  logic        Bus_wen = 1'b0;
  logic [31:0] Bus_wdata = '0;
  logic [31:0] Bus_rdata;
  logic [13:0] dram_addr;
  logic        dram_wen;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata = '0;
  logic [23:0] led;
  logic [23:0] sw = '0;
  logic [4:0]  button = '0;
  logic [7:0]  dig_en, dig_seg;

  int unsigned total = 0;
  int unsigned bad = 0;

  always #5 cpu_clk = ~cpu_clk;

  bus_bridge #(.DRAM_AW(14), .SCAN_DIV(4)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .Bus_addr(Bus_addr), .Bus_wen(Bus_wen),
    .Bus_wdata(Bus_wdata), .Bus_rdata(Bus_rdata), .dram_addr(dram_addr), .dram_wen(dram_wen),
    .dram_wdata(dram_wdata), .dram_rdata(dram_rdata), .led(led), .sw(sw), .button(button),
    .dig_en(dig_en), .dig_seg(dig_seg)
  );

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic test_reset();
    cpu_rst = 1'b0; Bus_wen = 1'b1; Bus_addr = 32'h0000_0040;
    #1;
    total++; if (dram_wen !== 1'b0) begin bad++; $display("FAIL rst_dram_wen got=%h exp=0", dram_wen); end
    step(); step();
    Bus_wen = 1'b0;
    total++; if (led !== 24'h0) begin bad++; $display("FAIL rst_led got=%h exp=0", led); end
    total++; if (dig_en !== 8'hFE) begin bad++; $display("FAIL rst_dig_en got=%h exp=fe", dig_en); end
    total++; if (dig_seg !== 8'hC0) begin bad++; $display("FAIL rst_dig_seg got=%h exp=c0", dig_seg); end
    Bus_addr = 32'hFFFF_F000; #1;
    total++; if (Bus_rdata !== 32'h0) begin bad++; $display("FAIL rst_dig_rd got=%h exp=0", Bus_rdata); end
    cpu_rst = 1'b1;
  endtask

  task automatic test_dram();
    Bus_addr = 32'h0000_0040; Bus_wen = 1'b1; Bus_wdata = 32'h1234_5678; dram_rdata = 32'hCAFE_BABE;
    #1;
    total++; if (dram_wen !== 1'b1) begin bad++; $display("FAIL dram_wen got=%h exp=1", dram_wen); end
    total++; if (dram_addr !== 14'h010) begin bad++; $display("FAIL dram_addr got=%h exp=010", dram_addr); end
    total++; if (dram_wdata !== 32'h1234_5678) begin bad++; $display("FAIL dram_wdata got=%h exp=12345678", dram_wdata); end
    total++; if (Bus_rdata !== 32'hCAFE_BABE) begin bad++; $display("FAIL dram_rd got=%h exp=cafebabe", Bus_rdata); end
    Bus_addr = 32'hFFFF_EFFC; #1;
    total++; if (dram_wen !== 1'b1) begin bad++; $display("FAIL dram_edge_wen got=%h exp=1", dram_wen); end
    total++; if (Bus_rdata !== 32'hCAFE_BABE) begin bad++; $display("FAIL dram_edge_rd got=%h exp=cafebabe", Bus_rdata); end
    Bus_addr = 32'hFFFF_F004; #1;
    total++; if (dram_wen !== 1'b0) begin bad++; $display("FAIL page_wen got=%h exp=0", dram_wen); end
    step();
    Bus_wen = 1'b0; #1;
    total++; if (Bus_rdata !== 32'h0) begin bad++; $display("FAIL unmapped_rd got=%h exp=0", Bus_rdata); end
  endtask

  task automatic test_led();
    Bus_addr = 32'hFFFF_F060; Bus_wen = 1'b1; Bus_wdata = 32'h00AB_CDEF;
    #1;
    total++; if (dram_wen !== 1'b0) begin bad++; $display("FAIL led_dram_wen got=%h exp=0", dram_wen); end
    step();
    Bus_wen = 1'b0; #1;
    total++; if (led !== 24'hABCDEF) begin bad++; $display("FAIL led_out got=%h exp=abcdef", led); end
    total++; if (Bus_rdata !== 32'h00AB_CDEF) begin bad++; $display("FAIL led_rd got=%h exp=00abcdef", Bus_rdata); end
    Bus_addr = 32'hFFFF_F070; Bus_wen = 1'b1; Bus_wdata = 32'hFFFF_FFFF;
    step();
    Bus_wen = 1'b0; #1;
    total++; if (led !== 24'hABCDEF) begin bad++; $display("FAIL sw_wr_led got=%h exp=abcdef", led); end
    total++; if (Bus_rdata !== 32'h0) begin bad++; $display("FAIL sw_wr_rd got=%h exp=0", Bus_rdata); end
  endtask

  task automatic test_sync();
    sw = 24'h5A5A5A; button = 5'b10001; Bus_addr = 32'hFFFF_F070;
    #1;
    total++; if (Bus_rdata !== 32'h0) begin bad++; $display("FAIL sw_sync0 got=%h exp=0", Bus_rdata); end
    step();
    total++; if (Bus_rdata !== 32'h0) begin bad++; $display("FAIL sw_sync1 got=%h exp=0", Bus_rdata); end
    step();
    total++; if (Bus_rdata !== 32'h005A_5A5A) begin bad++; $display("FAIL sw_sync2 got=%h exp=005a5a5a", Bus_rdata); end
    Bus_addr = 32'hFFFF_F078; #1;
    total++; if (Bus_rdata !== 32'h0000_0011) begin bad++; $display("FAIL btn_rd got=%h exp=11", Bus_rdata); end
  endtask

  task automatic test_scan();
    logic [7:0] en_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] seg_tab [8] = '{8'hC0, 8'h8E, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80};
    int unsigned d;
    cpu_rst = 1'b0; step();
    cpu_rst = 1'b1; Bus_addr = 32'hFFFF_F000; Bus_wen = 1'b1; Bus_wdata = 32'h8765_43F0;
    for (int k = 1; k <= 36; k++) begin
      step();
      Bus_wen = 1'b0;
      d = (k / 4) % 8;
      total++; if (dig_en !== en_tab[d]) begin bad++; $display("FAIL scan_en k=%0d got=%h exp=%h", k, dig_en, en_tab[d]); end
      total++; if (dig_seg !== seg_tab[d]) begin bad++; $display("FAIL scan_seg k=%0d got=%h exp=%h", k, dig_seg, seg_tab[d]); end
    end
    Bus_wen = 1'b1; Bus_wdata = 32'h8765_43A0;
    step();
    Bus_wen = 1'b0; #1;
    total++; if (dig_en !== 8'hFD) begin bad++; $display("FAIL dig_upd_en got=%h exp=fd", dig_en); end
    total++; if (dig_seg !== 8'h88) begin bad++; $display("FAIL dig_upd_seg got=%h exp=88", dig_seg); end
    total++; if (Bus_rdata !== 32'h8765_43A0) begin bad++; $display("FAIL dig_rd got=%h exp=876543a0", Bus_rdata); end
  endtask

  task automatic test_reset_mid();
    Bus_addr = 32'hFFFF_F060; Bus_wen = 1'b1; Bus_wdata = 32'h00FF_FFFF;
    step();
    total++; if (led !== 24'hFFFFFF) begin bad++; $display("FAIL mid_led_set got=%h exp=ffffff", led); end
    cpu_rst = 1'b0; Bus_addr = 32'h0000_0100; Bus_wen = 1'b1;
    #1;
    total++; if (dram_wen !== 1'b0) begin bad++; $display("FAIL mid_dram_wen got=%h exp=0", dram_wen); end
    Bus_addr = 32'hFFFF_F060; Bus_wdata = 32'h0012_3456;
    step();
    cpu_rst = 1'b1; Bus_wen = 1'b0; #1;
    total++; if (led !== 24'h0) begin bad++; $display("FAIL mid_led got=%h exp=0", led); end
    total++; if (dig_en !== 8'hFE) begin bad++; $display("FAIL mid_en got=%h exp=fe", dig_en); end
    total++; if (dig_seg !== 8'hC0) begin bad++; $display("FAIL mid_seg got=%h exp=c0", dig_seg); end
  endtask

  task automatic test_timer();
    logic [31:0] e10, e15, ew0, ew1, ew2;
`ifdef BRIDGE_TIMER_EN
    e10 = 32'd10; e15 = 32'd15; ew0 = 32'hFFFF_FFFE; ew1 = 32'hFFFF_FFFF; ew2 = 32'h0;
`else
    e10 = '0; e15 = '0; ew0 = '0; ew1 = '0; ew2 = '0;
`endif
    cpu_rst = 1'b0; step();
    cpu_rst = 1'b1; Bus_addr = 32'hFFFF_F020;
    for (int i = 0; i < 10; i++) step();
    total++; if (Bus_rdata !== e10) begin bad++; $display("FAIL tmr10 got=%h exp=%h", Bus_rdata, e10); end
    for (int i = 0; i < 5; i++) step();
    total++; if (Bus_rdata !== e15) begin bad++; $display("FAIL tmr15 got=%h exp=%h", Bus_rdata, e15); end
    Bus_wen = 1'b1; Bus_wdata = 32'hFFFF_FFFE;
    step();
    Bus_wen = 1'b0; #1;
    total++; if (Bus_rdata !== ew0) begin bad++; $display("FAIL tmr_ld got=%h exp=%h", Bus_rdata, ew0); end
    step();
    total++; if (Bus_rdata !== ew1) begin bad++; $display("FAIL tmr_ld1 got=%h exp=%h", Bus_rdata, ew1); end
    step();
    total++; if (Bus_rdata !== ew2) begin bad++; $display("FAIL tmr_wrap got=%h exp=%h", Bus_rdata, ew2); end
  endtask

  initial begin
    test_reset();
    test_dram();
    test_led();
    test_sync();
    test_scan();
    test_reset_mid();
    test_timer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
